// File: rtl/timer_ctrl_logic.sv
// timer_ctrl_logic: APB register block (TDR/TCR/TSR) and load/status control for the 8-bit timer.
// Optional TIMER_CTRL_IRQ_EN adds the TIER register at 0x03 and the irq output.
module timer_ctrl_logic #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W = 8
) (
  input  logic              PCLK,
  input  logic              RST,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [7:0]        PWDATA,
  output logic [7:0]        PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              over_flow,
  input  logic              under_flow,
  output logic [7:0]        TDR,
  output logic [7:0]        TCR,
  output logic [1:0]        Clk_SEL,
  output logic              load,
  output logic              OVF_rst,
  output logic              UNDF_rst
`ifdef TIMER_CTRL_IRQ_EN
  ,
  output logic              irq
`endif
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic [1:0] tsr, flag_q, rise, clr;
  logic sel_tdr, sel_tcr, sel_tsr, sel_tier, hit, wr;
  logic [7:0] rdata;
`ifdef TIMER_CTRL_IRQ_EN
  logic [1:0] tier;
  assign sel_tier = PADDR == ADDR_W'(3);
`else
  assign sel_tier = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    cnt_nx = '0;
    PREADY = 1'b0;
    if (state == IDLE) state_nx = (PSEL && !PENABLE) ? ACCESS : IDLE;
    else if (!PSEL) state_nx = IDLE;
    else if (cnt == WAIT_STATES[1:0]) begin
      PREADY = 1'b1;
      state_nx = IDLE;
    end
    else cnt_nx = cnt + 2'd1;
  end
  assign sel_tdr = PADDR == ADDR_W'(0);
  assign sel_tcr = PADDR == ADDR_W'(1);
  assign sel_tsr = PADDR == ADDR_W'(2);
  assign hit = sel_tdr | sel_tcr | sel_tsr | sel_tier;
  assign wr = PREADY & PWRITE & hit;
  assign PSLVERR = PREADY & ~hit;
  always_comb begin
    rdata = sel_tdr ? TDR : sel_tcr ? TCR : sel_tsr ? {6'b0, tsr} : 8'h00;
`ifdef TIMER_CTRL_IRQ_EN
    rdata = sel_tier ? {6'b0, tier} : rdata;
`endif
  end
  assign PRDATA = (PREADY && !PWRITE) ? rdata : 8'h00;
  assign Clk_SEL = TCR[1:0];
  // A same-cycle rising edge beats the W1C and swallows its clear pulse
  assign rise = {under_flow, over_flow} & ~flag_q;
  assign clr = (wr && sel_tsr) ? PWDATA[1:0] : 2'b00;
  always_ff @(posedge PCLK) begin
    if (!RST) begin
      state <= IDLE;
      cnt <= '0;
      flag_q <= '0;
      tsr <= '0;
      TDR <= '0;
      TCR <= '0;
      load <= 1'b0;
      OVF_rst <= 1'b0;
      UNDF_rst <= 1'b0;
`ifdef TIMER_CTRL_IRQ_EN
      tier <= '0;
      irq <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      flag_q <= {under_flow, over_flow};
      tsr <= (tsr & ~clr) | rise;
      if (wr && sel_tdr) TDR <= PWDATA;
      if (wr && sel_tcr) TCR <= PWDATA & 8'hB3;
      load <= wr & ((sel_tcr & PWDATA[7]) | (sel_tdr & TCR[7]));
      {UNDF_rst, OVF_rst} <= clr & ~rise;
`ifdef TIMER_CTRL_IRQ_EN
      if (wr && sel_tier) tier <= PWDATA[1:0];
      irq <= |(tsr & tier);
`endif
    end
  end
endmodule
